add64_seq: RTL and testbench

- Multi-cycle 64-bit add/subtract sequencer built around a single shared cla32 instance (32-bit ripple of eight cla4).
- Splits each 64-bit operation into a low-half pass and a high-half pass through the same cla32, with the inter-half carry registered between passes.
- Sits between a simple start/done command interface and the existing 32-bit adder datapath; it is the datapath's only driver.

---
 rtl/add64_seq_pkg.sv | 24 ++
 rtl/add64_seq_cla32.sv | 59 +++++
 rtl/add64_seq.sv | 116 +++++++++++
 tb/tb_add64_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/add64_seq_pkg.sv
// Shared types and widths for the 64-bit add/subtract sequencer.
// Split-pass datapath: one 32-bit cla32 used twice per operation.
package add64_seq_pkg;

  localparam int W  = 64;
  localparam int HW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Signed overflow of an add, given operand and sum sign bits.
  function automatic logic add_ovf(
    input logic sa,
    input logic sb,
    input logic ss
  );
    return (sa == sb) && (ss != sa);
  endfunction

endpackage

// File: rtl/add64_seq_cla32.sv
// 32-bit adder: ripple of eight 4-bit carry-lookahead blocks.
// Existing datapath block shared by the 64-bit sequencer.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [8:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 8; i++) begin : g_blk
    cla4 u_cla4 (
      .a  (a[4*i +: 4]),
      .b  (b[4*i +: 4]),
      .ci (c[i]),
      .s  (s[4*i +: 4]),
      .co (c[i+1])
    );
  end

  assign co = c[8];

endmodule

// File: rtl/add64_seq.sv
// 64-bit add/subtract in two passes through a shared cla32.
// Low half in LO, high half in HI, inter-half carry registered.
module add64_seq
  import add64_seq_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          op_start,
  input  logic          op_sub,
  input  logic [W-1:0]  op_a,
  input  logic [W-1:0]  op_b,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          co,
  output logic          ovf
);

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          sub_r;
  logic          c_r;
  logic [HW-1:0] lo_r;

  logic [HW-1:0] cla_a;
  logic [HW-1:0] cla_b;
  logic [HW-1:0] cla_s;
  logic          cla_ci;
  logic          cla_co;

  logic accept;

  assign accept = op_start
                & ((state_q == IDLE) | (state_q == DONE));

  assign busy = (state_q == LO) | (state_q == HI);
  assign done = (state_q == DONE);

  // Low-half selection is the default; only HI picks the top half.
  always_comb begin
    cla_a  = a_r[HW-1:0];
    cla_b  = b_r[HW-1:0];
    cla_ci = sub_r;
    unique case (1'b1)
      (state_q == HI): begin
        cla_a  = a_r[W-1:HW];
        cla_b  = b_r[W-1:HW];
        cla_ci = c_r;
      end
      default: ;
    endcase
  end

  cla32 U0_cla32 (
    .a  (cla_a),
    .b  (cla_b),
    .ci (cla_ci),
    .s  (cla_s),
    .co (cla_co)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (op_start) state_d = LO;
      LO:   state_d = HI;
      HI:   state_d = DONE;
      DONE: state_d = op_start ? LO : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sub_r <= 1'b0;
    end else if (accept) begin
      a_r   <= op_a;
      b_r   <= op_sub ? ~op_b : op_b;
      sub_r <= op_sub;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_r <= '0;
      c_r  <= 1'b0;
    end else if (state_q == LO) begin
      lo_r <= cla_s;
      c_r  <= cla_co;
    end
  end

  // b_r already holds ~b for subtract, so add-rule overflow applies.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else if (state_q == HI) begin
      result <= {cla_s, lo_r};
      co     <= cla_co;
      ovf    <= add_ovf(a_r[W-1], b_r[W-1], cla_s[HW-1]);
    end
  end

endmodule

// File: tb/tb_add64_seq.sv
// Directed and random checks for add64_seq.
// Expected values are hand-computed or from a 65-bit model.
module tb_add64_seq;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic        op_sub;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        co;
  logic        ovf;

  int tests;
  int fails;

  add64_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_start (op_start),
    .op_sub   (op_sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .co       (co),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one edge; returns in the LO cycle.
  task automatic start_op(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        sub
  );
    op_start = 1'b1;
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    tick();
    op_start = 1'b0;
    op_a     = {$urandom, $urandom};
    op_b     = {$urandom, $urandom};
    op_sub   = 1'($urandom);
  endtask

  // Returns in the DONE cycle; cyc counts cycles from the start edge.
  task automatic wait_done(
    output int cyc,
    output int bcnt
  );
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic run_chk(
    input string       tag,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        sub,
    input logic [63:0] er,
    input logic        eco,
    input logic        eovf
  );
    int cyc;
    int bcnt;
    start_op(a, b, sub);
    wait_done(cyc, bcnt);
    chk({tag, "_lat"}, 64'(cyc), 64'd3);
    chk({tag, "_busy"}, 64'(bcnt), 64'd2);
    chk({tag, "_res"}, result, er);
    chk({tag, "_co"}, 64'(co), 64'(eco));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eovf));
  endtask

  initial begin
    logic [64:0] ref65;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rs;
    logic        eovf;
    int          cyc;
    int          bcnt;

    tests    = 0;
    fails    = 0;
    reset_n  = 1'b0;
    op_start = 1'b0;
    op_sub   = 1'b0;
    op_a     = '0;
    op_b     = '0;

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_res", result, 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    #3 reset_n = 1'b1;
    tick();

    run_chk("carry", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0,
            64'h0000_0001_0000_0000, 1'b0, 1'b0);
    tick();
    run_chk("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
            64'd0, 1'b1, 1'b0);
    tick();
    run_chk("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1);
    tick();
    run_chk("sub57", 64'd5, 64'd7, 1'b1,
            64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    tick();
    run_chk("subovf", 64'h8000_0000_0000_0000, 64'd1, 1'b1,
            64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Starts during LO and HI must be ignored.
    tick();
    start_op(64'd10, 64'd20, 1'b0);
    op_start = 1'b1;
    op_a     = 64'hDEAD_BEEF_0000_0001;
    op_b     = 64'h1234_5678_9ABC_DEF0;
    op_sub   = 1'b1;
    tick();
    chk("hs_busy_hi", 64'(busy), 64'd1);
    tick();
    op_start = 1'b0;
    chk("hs_done", 64'(done), 64'd1);
    chk("hs_busy_dn", 64'(busy), 64'd0);
    chk("hs_res", result, 64'd30);

    // Back-to-back start in the DONE cycle.
    start_op(64'd2, 64'd3, 1'b0);
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_hold", result, 64'd30);
    wait_done(cyc, bcnt);
    chk("b2b_lat", 64'(cyc), 64'd3);
    chk("b2b_res", result, 64'd5);
    tick();
    chk("b2b_idle", 64'(done), 64'd0);

    // Reset asserted in HI: immediate clear, no done pulse.
    start_op(64'h1111_2222_3333_4444, 64'h5, 1'b0);
    tick();
    chk("rmid_inhi", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_done", 64'(done), 64'd0);
    chk("rmid_res", result, 64'd0);
    tick();
    chk("rmid_nodn", 64'(done), 64'd0);
    #3 reset_n = 1'b1;
    tick();
    chk("rmid_idle", 64'(done | busy), 64'd0);
    run_chk("postrst", 64'd100, 64'd23, 1'b0,
            64'd123, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom);
      if (rs) begin
        ref65 = {1'b0, ra} + {1'b0, ~rb} + 65'd1;
        eovf  = (ra[63] != rb[63]) && (ref65[63] != ra[63]);
      end else begin
        ref65 = {1'b0, ra} + {1'b0, rb};
        eovf  = (ra[63] == rb[63]) && (ref65[63] != ra[63]);
      end
      run_chk("rnd", ra, rb, rs,
              ref65[63:0], ref65[64], eovf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
